// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// controller FSM states and the forwarding priority helper.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } hazState_e;

  // MEM result is younger than WB data, so it wins when both match
  function automatic logic [1:0] fwdPick(input logic memHit, input logic wbHit);
    logic [1:0] sel;
    if (memHit) begin
      sel = FWD_MEM;
    end else if (wbHit) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_perf_counter.sv
// Free-running event counter; wraps modulo 2^CNT_W.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count one event per cycle in which inc is high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= {CNT_W{1'b0}};
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 5-stage RV32 core: forwarding selects, load-use
// stall, branch flush, data-memory wait freeze with timeout, perf counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int CNT_W        = 32,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              ex_memRead,
  input  logic              mem_regWrite,
  input  logic              wb_regWrite,
  input  logic              mem_PCSrc,
  input  logic              mem_access,
  input  logic              dmem_ready,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic [1:0]        fwdA,
  output logic [1:0]        fwdB,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  cyc_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam logic [REG_AW-1:0] REG_X0     = {REG_AW{1'b0}};
  localparam logic [15:0]       WAIT_LIMIT = 16'(WAIT_TIMEOUT);

  hazState_e         state;
  hazState_e         nextState;
  logic [15:0]       waitCnt;
  logic [15:0]       waitNext;
  logic              freeze;
  logic              branchFlush;
  logic              loadUse;
  logic              idV;
  logic              exV;
  logic              memV;
  logic              wbV;
  logic [REG_AW-1:0] exRs1;
  logic [REG_AW-1:0] exRs2;
  logic              memHitA;
  logic              memHitB;
  logic              wbHitA;
  logic              wbHitB;

  // Hazard classification: a pending memory access freezes everything,
  // a taken branch outranks the load-use check.
  always_comb begin
    freeze      = mem_access && !dmem_ready;
    branchFlush = !freeze && mem_PCSrc;
    loadUse     = 1'b0;
    if (!freeze && !mem_PCSrc && ex_memRead && (ex_rd != REG_X0)) begin
      loadUse = (id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd));
    end else begin
      loadUse = 1'b0;
    end
  end

  // Forwarding matches against the EX sources, only from live writing stages
  always_comb begin
    memHitA = mem_regWrite && memV && (mem_rd != REG_X0) && (mem_rd == exRs1);
    memHitB = mem_regWrite && memV && (mem_rd != REG_X0) && (mem_rd == exRs2);
    wbHitA  = wb_regWrite && wbV && (wb_rd != REG_X0) && (wb_rd == exRs1);
    wbHitB  = wb_regWrite && wbV && (wb_rd != REG_X0) && (wb_rd == exRs2);
  end

  // Pipeline enables, bubbles and forwarding selects
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    fwdA         = FWD_RF;
    fwdB         = FWD_RF;
    if (rst) begin
      if (freeze) begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        mem_wb_en = 1'b0;
      end else if (branchFlush) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (loadUse) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end else begin
        pc_en = 1'b1;
      end
      fwdA = fwdPick(memHitA, wbHitA);
      fwdB = fwdPick(memHitB, wbHitB);
    end else begin
      fwdA = FWD_RF;
      fwdB = FWD_RF;
    end
  end

  // Controller state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= nextState;
    end
  end

  // Next state and the saturating wait count for the coming cycle
  always_comb begin
    nextState = state;
    waitNext  = waitCnt;
    case (state)
      RUN: begin
        waitNext = 16'd1;
        if (freeze) begin
          nextState = MEMWAIT;
        end else begin
          nextState = RUN;
        end
      end
      MEMWAIT: begin
        if (waitCnt == WAIT_LIMIT) begin
          waitNext = waitCnt;
        end else begin
          waitNext = waitCnt + 16'd1;
        end
        if (dmem_ready) begin
          nextState = RUN;
        end else begin
          nextState = MEMWAIT;
        end
      end
      default: begin
        nextState = RUN;
        waitNext  = 16'd1;
      end
    endcase
  end

  // Consecutive-wait tracking; the timeout flag stays set until reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waitCnt     <= 16'd0;
      mem_timeout <= 1'b0;
    end else if (freeze) begin
      waitCnt     <= waitNext;
      mem_timeout <= mem_timeout || (waitNext == WAIT_LIMIT);
    end else begin
      waitCnt     <= 16'd0;
      mem_timeout <= mem_timeout;
    end
  end

  // Stage valid chain and EX source registers; a bubble carries no sources
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idV   <= 1'b0;
      exV   <= 1'b0;
      memV  <= 1'b0;
      wbV   <= 1'b0;
      exRs1 <= REG_X0;
      exRs2 <= REG_X0;
    end else if (freeze) begin
      idV   <= idV;
      exV   <= exV;
      memV  <= memV;
      wbV   <= wbV;
      exRs1 <= exRs1;
      exRs2 <= exRs2;
    end else begin
      idV   <= branchFlush ? 1'b0 : (loadUse ? idV : 1'b1);
      exV   <= (branchFlush || loadUse) ? 1'b0 : idV;
      memV  <= branchFlush ? 1'b0 : exV;
      wbV   <= memV;
      if (branchFlush || loadUse) begin
        exRs1 <= REG_X0;
        exRs2 <= REG_X0;
      end else begin
        exRs1 <= id_rs1_used ? id_rs1 : REG_X0;
        exRs2 <= id_rs2_used ? id_rs2 : REG_X0;
      end
    end
  end

  perf_counter #(.CNT_W(CNT_W)) uCycCnt (
    .clk (clk),
    .rst (rst),
    .inc (1'b1),
    .cnt (cyc_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) uStallCnt (
    .clk (clk),
    .rst (rst),
    .inc (freeze || loadUse),
    .cnt (stall_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) uFlushCnt (
    .clk (clk),
    .rst (rst),
    .inc (branchFlush),
    .cnt (flush_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) uRetireCnt (
    .clk (clk),
    .rst (rst),
    .inc (wbV && !freeze),
    .cnt (retire_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// stimulus against a stage-slot reference model of the pipeline.
module tb_pipe_hazard_ctrl;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic id_rs1_used, id_rs2_used, ex_memRead, mem_regWrite, wb_regWrite;
  logic mem_PCSrc, mem_access, dmem_ready;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_timeout;
  logic [1:0] fwdA, fwdB;
  logic [31:0] cyc_cnt, stall_cnt, flush_cnt, retire_cnt;
  wire [4:0] sEn;
  wire [2:0] sFl;
  wire [1:0] sFA, sFB;
  wire sTo;
  wire [3:0] sCyc, sStall, sFlush, sRet;

  pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(32), .WAIT_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd), .ex_memRead(ex_memRead),
    .mem_regWrite(mem_regWrite), .wb_regWrite(wb_regWrite), .mem_PCSrc(mem_PCSrc),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .fwdA(fwdA), .fwdB(fwdB), .mem_timeout(mem_timeout),
    .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .retire_cnt(retire_cnt)
  );

  // narrow-counter instance exercises wrap-around within a short run
  pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(4), .WAIT_TIMEOUT(TO)) dutSmall (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd), .ex_memRead(ex_memRead),
    .mem_regWrite(mem_regWrite), .wb_regWrite(wb_regWrite), .mem_PCSrc(mem_PCSrc),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_en(sEn[4]), .if_id_en(sEn[3]), .id_ex_en(sEn[2]), .ex_mem_en(sEn[1]),
    .mem_wb_en(sEn[0]), .if_id_flush(sFl[2]), .id_ex_flush(sFl[1]),
    .ex_mem_flush(sFl[0]), .fwdA(sFA), .fwdB(sFB), .mem_timeout(sTo),
    .cyc_cnt(sCyc), .stall_cnt(sStall), .flush_cnt(sFlush), .retire_cnt(sRet)
  );

  int checks = 0;
  int passes = 0;

  // reference model: slot valid bits [0]=ID [1]=EX [2]=MEM [3]=WB
  bit [3:0] mV;
  logic [4:0] mRs1, mRs2;
  int unsigned mCyc, mStall, mFlush, mRet;
  bit mTo;
  int mRun;
  bit eFrz, eBr, eLu;
  logic [4:0] eEn;
  logic [2:0] eFl;
  logic [1:0] eFA, eFB;

  function automatic logic [1:0] srcFwd(input logic [4:0] s);
    if (s != 5'd0 && mem_regWrite && mV[2] && mem_rd == s) return 2'b10;
    if (s != 5'd0 && wb_regWrite && mV[3] && wb_rd == s) return 2'b01;
    return 2'b00;
  endfunction

  task automatic mdlReset();
    mV = 4'b0; mRs1 = 5'd0; mRs2 = 5'd0;
    mCyc = 0; mStall = 0; mFlush = 0; mRet = 0; mTo = 1'b0; mRun = 0;
  endtask

  task automatic modelComb();
    eFrz = mem_access && !dmem_ready;
    eBr  = !eFrz && mem_PCSrc;
    eLu  = !eFrz && !eBr && ex_memRead && ex_rd != 5'd0 &&
           ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    if (!rst) begin
      eEn = 5'b11111; eFl = 3'b000; eFA = 2'b00; eFB = 2'b00;
    end else begin
      eEn = eFrz ? 5'b00000 : (eLu ? 5'b00111 : 5'b11111);
      eFl = {eBr, eBr || eLu, eBr};
      eFA = srcFwd(mRs1);
      eFB = srcFwd(mRs2);
    end
  endtask

  // one clock edge, model advanced with the inputs seen at that edge
  task automatic tick();
    modelComb();
    @(posedge clk);
    if (rst) begin
      mCyc++;
      if (eFrz || eLu) mStall++;
      if (eBr) mFlush++;
      if (mV[3] && !eFrz) mRet++;
      if (eFrz) begin
        mRun = (mRun >= TO) ? TO : mRun + 1;
        if (mRun >= TO) mTo = 1'b1;
      end else begin
        mRun = 0;
      end
      if (!eFrz) begin
        mV[3] = mV[2];
        mV[2] = eBr ? 1'b0 : mV[1];
        mV[1] = (eBr || eLu) ? 1'b0 : mV[0];
        mV[0] = eBr ? 1'b0 : (eLu ? mV[0] : 1'b1);
        mRs1 = (eBr || eLu || !id_rs1_used) ? 5'd0 : id_rs1;
        mRs2 = (eBr || eLu || !id_rs2_used) ? 5'd0 : id_rs2;
      end
    end
    #1;
  endtask

  task automatic setIdle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0; ex_memRead = 1'b0;
    mem_regWrite = 1'b0; wb_regWrite = 1'b0; mem_PCSrc = 1'b0;
    mem_access = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic fill();
    repeat (4) begin setIdle(); tick(); end
  endtask

  task automatic test_reset();
    setIdle();
    mem_access = 1'b1; dmem_ready = 1'b0; mem_PCSrc = 1'b1;
    ex_memRead = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    mdlReset();
    #1;
    checks++;
    if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} !== 5'b11111)
      $display("FAIL rst_enables got=%b exp=11111", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en});
    else passes++;
    checks++;
    if ({if_id_flush, id_ex_flush, ex_mem_flush, fwdA, fwdB} !== 7'd0)
      $display("FAIL rst_flush_fwd got=%b exp=0", {if_id_flush, id_ex_flush, ex_mem_flush, fwdA, fwdB});
    else passes++;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({cyc_cnt, stall_cnt, flush_cnt, retire_cnt, mem_timeout} !== 129'd0)
      $display("FAIL rst_state cyc=%0d stall=%0d flush=%0d ret=%0d to=%b exp=all 0",
               cyc_cnt, stall_cnt, flush_cnt, retire_cnt, mem_timeout);
    else passes++;
    setIdle();
    rst = 1'b1;
  endtask

  task automatic test_alu_stream();
    for (int c = 1; c <= 10; c++) begin
      setIdle();
      id_rs1 = 5'($urandom_range(1, 15)); id_rs2 = 5'($urandom_range(1, 15));
      id_rs1_used = 1'b1; id_rs2_used = 1'b1;
      ex_rd = 5'($urandom_range(16, 31)); mem_rd = 5'($urandom_range(16, 31));
      wb_rd = 5'($urandom_range(16, 31)); mem_regWrite = 1'b1; wb_regWrite = 1'b1;
      #1;
      checks++;
      if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
           ex_mem_flush, fwdA, fwdB} !== 12'b11111_000_00_00)
        $display("FAIL alu_ctrl cycle=%0d got=%b exp=111110000000", c,
                 {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
                  ex_mem_flush, fwdA, fwdB});
      else passes++;
      tick();
      if (c == 4 || c == 5) begin
        checks++;
        if (retire_cnt !== ((c == 5) ? 32'd1 : 32'd0))
          $display("FAIL alu_first_retire cycle=%0d got=%0d exp=%0d", c, retire_cnt, (c == 5) ? 1 : 0);
        else passes++;
      end
    end
    checks++;
    if (retire_cnt !== 32'd6 || cyc_cnt !== 32'd10 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0)
      $display("FAIL alu_counts ret=%0d cyc=%0d stall=%0d flush=%0d exp=6 10 0 0",
               retire_cnt, cyc_cnt, stall_cnt, flush_cnt);
    else passes++;
  endtask

  task automatic test_load_use();
    int unsigned s0;
    fill();
    s0 = mStall;
    setIdle();
    ex_memRead = 1'b1; ex_rd = 5'd5;
    id_rs1 = 5'd5; id_rs1_used = 1'b1; id_rs2 = 5'd7; id_rs2_used = 1'b1;
    #1;
    checks++;
    if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, id_ex_flush, if_id_flush, ex_mem_flush} !== 8'b00111_100)
      $display("FAIL lu_stall got=%b exp=00111100",
               {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, id_ex_flush, if_id_flush, ex_mem_flush});
    else passes++;
    tick();
    setIdle();
    mem_rd = 5'd5; mem_regWrite = 1'b1;
    id_rs1 = 5'd5; id_rs1_used = 1'b1; id_rs2 = 5'd7; id_rs2_used = 1'b1;
    #1;
    checks++;
    if ({pc_en, id_ex_flush, fwdA} !== 4'b1000)
      $display("FAIL lu_bubble got=%b exp=1000", {pc_en, id_ex_flush, fwdA});
    else passes++;
    tick();
    setIdle();
    wb_rd = 5'd5; wb_regWrite = 1'b1;
    #1;
    checks++;
    if (fwdA !== 2'b01 || fwdB !== 2'b00)
      $display("FAIL lu_fwd fwdA=%b fwdB=%b exp=01 00", fwdA, fwdB);
    else passes++;
    tick();
    checks++;
    if (stall_cnt !== s0 + 32'd1)
      $display("FAIL lu_stall_cnt got=%0d exp=%0d", stall_cnt, s0 + 1);
    else passes++;
  endtask

  task automatic test_forwarding();
    fill();
    setIdle();
    id_rs1 = 5'd3; id_rs2 = 5'd3; id_rs1_used = 1'b1; id_rs2_used = 1'b1;
    tick();
    setIdle();
    mem_rd = 5'd3; mem_regWrite = 1'b1; wb_rd = 5'd3; wb_regWrite = 1'b1;
    #1;
    checks++;
    if ({fwdA, fwdB} !== 4'b1010) $display("FAIL fwd_mem_prio got=%b exp=1010", {fwdA, fwdB});
    else passes++;
    mem_regWrite = 1'b0;
    #1;
    checks++;
    if ({fwdA, fwdB} !== 4'b0101) $display("FAIL fwd_wb got=%b exp=0101", {fwdA, fwdB});
    else passes++;
    mem_regWrite = 1'b1; mem_rd = 5'd4;
    #1;
    checks++;
    if ({fwdA, fwdB} !== 4'b0101) $display("FAIL fwd_mem_miss got=%b exp=0101", {fwdA, fwdB});
    else passes++;
    setIdle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b1; id_rs2_used = 1'b1;
    tick();
    setIdle();
    mem_rd = 5'd0; mem_regWrite = 1'b1; wb_rd = 5'd0; wb_regWrite = 1'b1;
    #1;
    checks++;
    if ({fwdA, fwdB} !== 4'b0000) $display("FAIL fwd_x0 got=%b exp=0000", {fwdA, fwdB});
    else passes++;
  endtask

  task automatic test_branch_flush();
    int unsigned f0, r0;
    fill();
    f0 = mFlush;
    setIdle();
    mem_PCSrc = 1'b1;
    ex_memRead = 1'b1; ex_rd = 5'd2; id_rs1 = 5'd2; id_rs1_used = 1'b1;
    #1;
    checks++;
    if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, ex_mem_flush} !== 8'b11111_111)
      $display("FAIL br_flush got=%b exp=11111111",
               {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, ex_mem_flush});
    else passes++;
    tick();
    r0 = mRet;
    setIdle();
    #1;
    checks++;
    if ({if_id_flush, id_ex_flush, ex_mem_flush} !== 3'b000 || flush_cnt !== f0 + 32'd1)
      $display("FAIL br_one_cycle flushes=%b cnt=%0d exp=000 %0d",
               {if_id_flush, id_ex_flush, ex_mem_flush}, flush_cnt, f0 + 1);
    else passes++;
    repeat (4) tick();
    checks++;
    if (retire_cnt !== r0 + 32'd1) $display("FAIL br_retire_gap got=%0d exp=%0d", retire_cnt, r0 + 1);
    else passes++;
    tick();
    checks++;
    if (retire_cnt !== r0 + 32'd2) $display("FAIL br_retire_resume got=%0d exp=%0d", retire_cnt, r0 + 2);
    else passes++;
  endtask

  task automatic test_mem_timeout();
    int unsigned s0;
    fill();
    s0 = mStall;
    for (int k = 1; k <= 6; k++) begin
      setIdle();
      mem_access = 1'b1; dmem_ready = 1'b0;
      ex_memRead = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
      #1;
      checks++;
      if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, ex_mem_flush} !== 8'd0)
        $display("FAIL frz_ctrl wait=%0d got=%b exp=00000000", k,
                 {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, ex_mem_flush});
      else passes++;
      tick();
      checks++;
      if (mem_timeout !== (k >= TO)) $display("FAIL frz_timeout wait=%0d got=%b exp=%b", k, mem_timeout, k >= TO);
      else passes++;
    end
    setIdle();
    #1;
    checks++;
    if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} !== 5'b11111)
      $display("FAIL frz_release got=%b exp=11111", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en});
    else passes++;
    tick();
    tick();
    checks++;
    if (mem_timeout !== 1'b1 || stall_cnt !== s0 + 32'd6)
      $display("FAIL frz_sticky to=%b stall=%0d exp=1 %0d", mem_timeout, stall_cnt, s0 + 6);
    else passes++;
  endtask

  task automatic test_deferred_flush_reset();
    int unsigned f0;
    fill();
    f0 = mFlush;
    for (int k = 1; k <= 3; k++) begin
      setIdle();
      mem_access = 1'b1; dmem_ready = 1'b0; mem_PCSrc = 1'b1;
      #1;
      checks++;
      if ({if_id_flush, id_ex_flush, ex_mem_flush, pc_en} !== 4'b0000)
        $display("FAIL dfr_wait wait=%0d got=%b exp=0000", k, {if_id_flush, id_ex_flush, ex_mem_flush, pc_en});
      else passes++;
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    checks++;
    if ({if_id_flush, id_ex_flush, ex_mem_flush} !== 3'b111)
      $display("FAIL dfr_release got=%b exp=111", {if_id_flush, id_ex_flush, ex_mem_flush});
    else passes++;
    tick();
    setIdle();
    #1;
    checks++;
    if ({if_id_flush, id_ex_flush, ex_mem_flush} !== 3'b000 || flush_cnt !== f0 + 32'd1)
      $display("FAIL dfr_once flushes=%b cnt=%0d exp=000 %0d",
               {if_id_flush, id_ex_flush, ex_mem_flush}, flush_cnt, f0 + 1);
    else passes++;
    mem_access = 1'b1; dmem_ready = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b0;
    mdlReset();
    #1;
    checks++;
    if ({cyc_cnt, stall_cnt, flush_cnt, retire_cnt, mem_timeout} !== 129'd0 ||
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} !== 5'b11111)
      $display("FAIL async_rst cyc=%0d stall=%0d to=%b en=%b exp=0 0 0 11111",
               cyc_cnt, stall_cnt, mem_timeout, {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en});
    else passes++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 1; k <= TO; k++) begin
      tick();
      checks++;
      if (mem_timeout !== (k >= TO))
        $display("FAIL rst_wait_restart wait=%0d got=%b exp=%b", k, mem_timeout, k >= TO);
      else passes++;
    end
    setIdle();
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_rs1_used = 1'($urandom_range(0, 1)); id_rs2_used = 1'($urandom_range(0, 1));
      ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
      wb_rd = 5'($urandom_range(0, 3));
      ex_memRead = ($urandom_range(0, 99) < 30);
      mem_regWrite = ($urandom_range(0, 99) < 60);
      wb_regWrite = ($urandom_range(0, 99) < 60);
      mem_PCSrc = ($urandom_range(0, 99) < 10);
      mem_access = ($urandom_range(0, 99) < 30);
      dmem_ready = ($urandom_range(0, 99) < 60);
      #1;
      modelComb();
      checks++;
      if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
           ex_mem_flush, fwdA, fwdB} !== {eEn, eFl, eFA, eFB})
        $display("FAIL rnd_ctrl cycle=%0d got=%b exp=%b", c,
                 {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
                  ex_mem_flush, fwdA, fwdB}, {eEn, eFl, eFA, eFB});
      else passes++;
      tick();
      checks++;
      if ({cyc_cnt, stall_cnt, flush_cnt, retire_cnt, mem_timeout} !== {mCyc, mStall, mFlush, mRet, mTo})
        $display("FAIL rnd_cnt cycle=%0d got=%0d/%0d/%0d/%0d/%b exp=%0d/%0d/%0d/%0d/%b", c,
                 cyc_cnt, stall_cnt, flush_cnt, retire_cnt, mem_timeout, mCyc, mStall, mFlush, mRet, mTo);
      else passes++;
      checks++;
      if ({sCyc, sStall, sFlush, sRet} !== {4'(mCyc), 4'(mStall), 4'(mFlush), 4'(mRet)})
        $display("FAIL rnd_wrap cycle=%0d got=%h exp=%h", c, {sCyc, sStall, sFlush, sRet},
                 {4'(mCyc), 4'(mStall), 4'(mFlush), 4'(mRet)});
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_alu_stream();
    test_load_use();
    test_forwarding();
    test_branch_flush();
    test_mem_timeout();
    test_deferred_flush_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
